// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone widths and arbiter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Saturating cycle counter with clear/enable and a one-cycle
//               terminal-count pulse when an enabled count reaches LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int                 c_cnt_w = $clog2(LIMIT) + 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

    logic [c_cnt_w-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == c_limit);

    // The terminal pulse restarts the count so a persistent enable never rewraps.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master Wishbone classic arbiter, VGA (m1) priority with a
//               CPU (m0) starvation limiter and a slave-ack watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int VGA_BURST_MAX = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic             clk_i,
    input  logic             reset_n,

    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o
);

    localparam int                   c_starv_w   = $clog2(VGA_BURST_MAX) + 1;
    localparam logic [c_starv_w-1:0] c_burst_max = c_starv_w'(VGA_BURST_MAX);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_starv_w-1:0] r_starv_cnt;
    logic [c_starv_w-1:0] w_starv_nxt;

    logic w_own0;
    logic w_own1;
    logic w_starve;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_timeout;

    assign w_own0   = (r_state == ARB_OWN0);
    assign w_own1   = (r_state == ARB_OWN1);
    assign w_starve = (r_starv_cnt == c_burst_max);
    assign gnt_o    = {w_own1, w_own0};

    // Watchdog runs only while the owner's strobe waits on the slave.
    assign w_wd_en  = (w_own0 || w_own1) && w_own_stb && !s_ack_i;
    assign w_wd_clr = !w_wd_en;

    wb_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .i_clr   (w_wd_clr),
        .i_en    (w_wd_en),
        .o_tc    (w_timeout)
    );

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        if (w_own1) begin
            w_own_cyc = m1_cyc_i;
            w_own_stb = m1_stb_i;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
        end else if (w_own0) begin
            w_own_cyc = m0_cyc_i;
            w_own_stb = m0_stb_i;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
        end
    end

    // A timeout can only fire without s_ack_i, so ack always wins that cycle.
    assign s_cyc_o  = w_own_cyc && !w_timeout;
    assign s_stb_o  = w_own_stb && !w_timeout;

    assign m0_ack_o = w_own0 && s_ack_i;
    assign m0_err_o = w_own0 && w_timeout;
    assign m0_dat_o = w_own0 ? s_dat_i : '0;
    assign m1_ack_o = w_own1 && s_ack_i;
    assign m1_err_o = w_own1 && w_timeout;
    assign m1_dat_o = w_own1 ? s_dat_i : '0;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ARB_IDLE;
            r_starv_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_starv_cnt <= w_starv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_starv_nxt = r_starv_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (m1_cyc_i && !(m0_cyc_i && w_starve)) begin
                    w_state_nxt = ARB_OWN1;
                    if (!m0_cyc_i) begin
                        w_starv_nxt = '0;
                    end else if (!w_starve) begin
                        w_starv_nxt = r_starv_cnt + 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    w_state_nxt = ARB_OWN0;
                    w_starv_nxt = '0;
                end else begin
                    w_starv_nxt = '0;
                end
            end
            ARB_OWN0: begin
                if (!m0_cyc_i || w_timeout) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (!m1_cyc_i || w_timeout) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Directed self-checking bench for wb_arbiter2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic [3:0]  m0_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [3:0]  m1_sel_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;

    logic        slv_auto  = 1'b0;
    logic        slv_force = 1'b0;
    logic        slv_ack_q = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Registered slave: one-cycle ack the cycle after a strobe is seen.
    always @(posedge clk_i) slv_ack_q <= slv_auto && s_stb_o && !slv_ack_q;
    always_comb s_ack_i = slv_ack_q || slv_force;

    wb_arbiter2 #(.VGA_BURST_MAX(8), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic test_reset();
        reset_n = 1'b0;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== 5'b0) begin
            errors++; $display("FAIL reset_bus: got %b expected 00000", {gnt_o, s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin
            errors++; $display("FAIL reset_acks: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        reset_n = 1'b1;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++; $display("FAIL reset_release_gnt: got %b expected 00", gnt_o);
        end
    endtask

    task automatic test_m0_read();
        @(negedge clk_i);
        m0_adr_i = 32'h1000_0040; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++; $display("FAIL m0_grant: got %b expected 01", gnt_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_adr_o, s_sel_o} !== {2'b11, 32'h1000_0040, 4'hF}) begin
            errors++; $display("FAIL m0_slave_mux: got %h expected %h",
                               {s_cyc_o, s_stb_o, s_adr_o, s_sel_o}, {2'b11, 32'h1000_0040, 4'hF});
        end
        @(negedge clk_i);
        checks++;
        if (m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL m0_early_ack: got %b expected 0", m0_ack_o);
        end
        s_dat_i = 32'hDEAD_BEEF; slv_force = 1'b1;
        #1;
        checks++;
        if ({m0_ack_o, m0_err_o, m0_dat_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL m0_read_ack: got %h expected %h", {m0_ack_o, m0_err_o, m0_dat_o}, {2'b10, 32'hDEAD_BEEF});
        end
        checks++;
        if ({m1_ack_o, m1_dat_o} !== 33'b0) begin
            errors++; $display("FAIL m0_nonowner_quiet: got %h expected 0", {m1_ack_o, m1_dat_o});
        end
        @(negedge clk_i);
        slv_force = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++; $display("FAIL m0_release_idle: got %b expected 00", gnt_o);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk_i);
        m0_adr_i = 32'h0000_1000; m0_dat_i = 32'hCAFE_0000; m0_we_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 32'h8000_0200; m1_sel_i = 4'hF; m1_we_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({gnt_o, s_adr_o} !== {2'b10, 32'h8000_0200}) begin
            errors++; $display("FAIL sim_m1_first: got %h expected %h", {gnt_o, s_adr_o}, {2'b10, 32'h8000_0200});
        end
        s_dat_i = 32'h1234_5678; slv_force = 1'b1;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o, m1_dat_o} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL sim_m1_ack: got %h expected %h", {m1_ack_o, m0_ack_o, m1_dat_o}, {2'b10, 32'h1234_5678});
        end
        @(negedge clk_i);
        slv_force = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++; $display("FAIL sim_dead_cycle: got %b expected 00", gnt_o);
        end
        @(negedge clk_i);
        checks++;
        if ({gnt_o, s_we_o, s_dat_o} !== {2'b01, 1'b1, 32'hCAFE_0000}) begin
            errors++; $display("FAIL sim_m0_second: got %h expected %h", {gnt_o, s_we_o, s_dat_o}, {2'b01, 1'b1, 32'hCAFE_0000});
        end
        slv_force = 1'b1;
        #1;
        checks++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
            errors++; $display("FAIL sim_m0_ack: got %b expected 10", {m0_ack_o, m1_ack_o});
        end
        @(negedge clk_i);
        slv_force = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_starvation();
        logic [1:0] seq[$];
        logic [1:0] prev;
        logic [1:0] exp;
        int         m1_done;
        bit         m0_done;
        int         cyc;
        m1_done = 0; m0_done = 1'b0; prev = 2'b00; cyc = 0;
        slv_auto = 1'b1;
        @(negedge clk_i);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        while (cyc < 400 && !(m1_done == 20 && m0_done)) begin
            @(negedge clk_i);
            cyc++;
            if (gnt_o != 2'b00 && prev == 2'b00) seq.push_back(gnt_o);
            prev = gnt_o;
            if (m1_ack_o) begin
                m1_done++; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end else if (!m1_cyc_i && m1_done < 20) begin
                m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            end
            if (m0_ack_o) begin
                m0_done = 1'b1; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end
        end
        slv_auto = 1'b0;
        checks++;
        if (cyc >= 400) begin
            errors++; $display("FAIL starve_budget: got %0d cycles expected under 400", cyc);
        end
        checks++;
        if (seq.size() != 21) begin
            errors++; $display("FAIL starve_grant_count: got %0d expected 21", seq.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            exp = (i == 8) ? 2'b01 : 2'b10;
            checks++;
            if (seq[i] !== exp) begin
                errors++; $display("FAIL starve_grant_%0d: got %b expected %b", i, seq[i], exp);
            end
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_timeout();
        int errk;
        errk = -1;
        @(negedge clk_i);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({gnt_o, s_stb_o} !== 3'b101) begin
            errors++; $display("FAIL to_grant: got %b expected 101", {gnt_o, s_stb_o});
        end
        for (int k = 1; k <= 300 && errk < 0; k++) begin
            @(negedge clk_i);
            if (m1_err_o) errk = k;
        end
        checks++;
        if (errk != 255) begin
            errors++; $display("FAIL to_err_delay: got %0d expected 255", errk);
        end
        checks++;
        if ({gnt_o, s_cyc_o, s_stb_o, m1_ack_o, m0_err_o} !== 6'b100000) begin
            errors++; $display("FAIL to_forced_drop: got %b expected 100000", {gnt_o, s_cyc_o, s_stb_o, m1_ack_o, m0_err_o});
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({gnt_o, m1_err_o} !== 3'b000) begin
            errors++; $display("FAIL to_err_single: got %b expected 000", {gnt_o, m1_err_o});
        end
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++; $display("FAIL to_m0_after: got %b expected 01", gnt_o);
        end
        slv_force = 1'b1;
        @(negedge clk_i);
        slv_force = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        m1_adr_i = 32'h8000_0400; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({gnt_o, s_stb_o} !== 3'b101) begin
            errors++; $display("FAIL rm_grant: got %b expected 101", {gnt_o, s_stb_o});
        end
        #2;
        reset_n = 1'b0; slv_force = 1'b1;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m1_ack_o, gnt_o} !== 5'b0) begin
            errors++; $display("FAIL rm_async: got %b expected 00000", {s_cyc_o, s_stb_o, m1_ack_o, gnt_o});
        end
        @(negedge clk_i);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; slv_force = 1'b0;
        @(negedge clk_i);
        reset_n = 1'b1;
        @(negedge clk_i);
        slv_force = 1'b1;
        #1;
        checks++;
        if ({m1_ack_o, m1_err_o, gnt_o} !== 4'b0) begin
            errors++; $display("FAIL rm_late_ack: got %b expected 0000", {m1_ack_o, m1_err_o, gnt_o});
        end
        @(negedge clk_i);
        slv_force = 1'b0;
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++; $display("FAIL rm_stay_idle: got %b expected 00", gnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
